// File: rtl/mc_seq_if.sv
// Shared memory port between the sequencer (master) and the memory system (slave).
// Instruction fetch and load/store data accesses both go through this one port.
interface mc_seq_if;
    logic mem_req;
    logic mem_dsel;
    logic mem_we;
    logic mem_ack;

    modport master (
        output mem_req,
        output mem_dsel,
        output mem_we,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_dsel,
        input  mem_we,
        output mem_ack
    );
endinterface

// File: rtl/mc_seq.sv
// Multi-cycle sequencer for the RV32I core: walks FETCH/DECODE/EXEC/MEM/WB, gates the datapath
// strobes, owns the shared memory port and traps ecall, illegal opcodes and memory timeouts.
module mc_seq #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [6:0]       Op,
    input  logic             resume,
    mc_seq_if.master         mem,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [2:0]       state,
    output logic             halted,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] instret
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_FAULT  = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        OC_WB      = 3'd0,
        OC_LOAD    = 3'd1,
        OC_STORE   = 3'd2,
        OC_BRANCH  = 3'd3,
        OC_ECALL   = 3'd4,
        OC_ILLEGAL = 3'd5
    } opclass_e;

    localparam logic [1:0] FC_ILLEGAL = 2'd1;
    localparam logic [1:0] FC_FETCH   = 2'd2;
    localparam logic [1:0] FC_DATA    = 2'd3;

    state_e            state_q,     state_d;
    opclass_e          opClass_q,   opClass_d;
    opclass_e          opDecoded;
    logic [WAIT_W-1:0] waitCnt_q,   waitCnt_d;
    logic [1:0]        faultCode_q, faultCode_d;
    logic [CNT_W-1:0]  instret_q,   instret_d;

    always_comb begin
        opDecoded = OC_ILLEGAL;
        case (Op)
            7'b0110011, 7'b0010011, 7'b1101111,
            7'b1100111, 7'b0110111, 7'b0010111: opDecoded = OC_WB;
            7'b0000011:                         opDecoded = OC_LOAD;
            7'b0100011:                         opDecoded = OC_STORE;
            7'b1100011:                         opDecoded = OC_BRANCH;
            7'b1110011:                         opDecoded = OC_ECALL;
            default:                            opDecoded = OC_ILLEGAL;
        endcase
    end

    // Class is latched in DECODE so EXEC/MEM/WB, and mem_we in particular, depend on state alone.
    always_comb begin
        state_d      = state_q;
        opClass_d    = opClass_q;
        waitCnt_d    = '0;
        faultCode_d  = faultCode_q;
        mem.mem_req  = 1'b0;
        mem.mem_dsel = 1'b0;
        mem.mem_we   = 1'b0;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        RegWrite     = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;

            S_FETCH: begin
                mem.mem_req = 1'b1;
                if (mem.mem_ack) begin
                    IRWrite = 1'b1;
                    state_d = S_DECODE;
                end else if (waitCnt_q == WAIT_LAST) begin
                    faultCode_d = FC_FETCH;
                    state_d     = S_FAULT;
                end else begin
                    waitCnt_d = waitCnt_q + 1'b1;
                end
            end

            S_DECODE: begin
                opClass_d = opDecoded;
                case (opDecoded)
                    OC_ILLEGAL: begin
                        faultCode_d = FC_ILLEGAL;
                        state_d     = S_FAULT;
                    end
                    OC_ECALL: state_d = S_HALT;
                    default:  state_d = S_EXEC;
                endcase
            end

            S_EXEC: begin
                case (opClass_q)
                    OC_BRANCH: begin
                        PCWrite = 1'b1;
                        state_d = S_FETCH;
                    end
                    OC_LOAD, OC_STORE: state_d = S_MEM;
                    default:           state_d = S_WB;
                endcase
            end

            S_MEM: begin
                mem.mem_req  = 1'b1;
                mem.mem_dsel = 1'b1;
                mem.mem_we   = (opClass_q == OC_STORE);
                if (mem.mem_ack) begin
                    if (opClass_q == OC_STORE) begin
                        PCWrite = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (waitCnt_q == WAIT_LAST) begin
                    faultCode_d = FC_DATA;
                    state_d     = S_FAULT;
                end else begin
                    waitCnt_d = waitCnt_q + 1'b1;
                end
            end

            S_WB: begin
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                state_d  = S_FETCH;
            end

            S_HALT: begin
                if (resume) begin
                    PCWrite = 1'b1;
                    state_d = S_FETCH;
                end
            end

            S_FAULT: state_d = S_FAULT;
        endcase
    end

    // Every PCWrite marks an instruction retiring, so it alone advances instret.
    assign instret_d = PCWrite ? instret_q + 1'b1 : instret_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            opClass_q   <= OC_ILLEGAL;
            waitCnt_q   <= '0;
            faultCode_q <= '0;
            instret_q   <= '0;
        end else begin
            state_q     <= state_d;
            opClass_q   <= opClass_d;
            waitCnt_q   <= waitCnt_d;
            faultCode_q <= faultCode_d;
            instret_q   <= instret_d;
        end
    end

    assign state      = state_q;
    assign halted     = (state_q == S_HALT);
    assign fault      = (state_q == S_FAULT);
    assign fault_code = faultCode_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_mc_seq.sv
// Randomized bench for mc_seq: a per-instruction trace model predicts every cycle's outputs.
module tb_mc_seq;
    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 4;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    typedef struct packed {
        logic [2:0]       st;
        logic             req;
        logic             dsel;
        logic             we;
        logic             irw;
        logic             pcw;
        logic             rw;
        logic             halted;
        logic             fault;
        logic [1:0]       code;
        logic [CNT_W-1:0] instret;
    } outs_t;

    typedef struct {
        logic [6:0] op;
        logic       ack;
        logic       res;
        outs_t      exp;
    } step_t;

    logic             clk    = 1'b0;
    logic             rstn   = 1'b1;
    logic [6:0]       Op     = '0;
    logic             resume = 1'b0;
    logic             IRWrite, PCWrite, RegWrite, halted, fault;
    logic [2:0]       state;
    logic [1:0]       fault_code;
    logic [CNT_W-1:0] instret;

    mc_seq_if memBus ();

    mc_seq #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rstn(rstn), .Op(Op), .resume(resume), .mem(memBus),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .state(state),
        .halted(halted), .fault(fault), .fault_code(fault_code), .instret(instret)
    );

    always #5 clk = ~clk;

    step_t plan[$];
    int    modelInstret;
    int    checks = 0;
    int    errors = 0;

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit isLegal(input logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
                          OP_LUI, OP_AUIPC, OP_ECALL};
    endfunction

    function automatic outs_t sampleOutputs();
        outs_t o;
        o.st      = state;
        o.req     = memBus.mem_req;
        o.dsel    = memBus.mem_dsel;
        o.we      = memBus.mem_we;
        o.irw     = IRWrite;
        o.pcw     = PCWrite;
        o.rw      = RegWrite;
        o.halted  = halted;
        o.fault   = fault;
        o.code    = fault_code;
        o.instret = instret;
        return o;
    endfunction

    // A retiring cycle shows the old count; the next cycle shows it incremented modulo 2^CNT_W.
    task automatic pushStep(input logic [6:0] op, input logic ack, input logic res,
                            input logic [2:0] st, input logic req, input logic dsel,
                            input logic we, input logic irw, input logic pcw,
                            input logic rw, input logic [1:0] code);
        step_t s;
        s.op          = op;
        s.ack         = ack;
        s.res         = res;
        s.exp.st      = st;
        s.exp.req     = req;
        s.exp.dsel    = dsel;
        s.exp.we      = we;
        s.exp.irw     = irw;
        s.exp.pcw     = pcw;
        s.exp.rw      = rw;
        s.exp.halted  = (st == 3'd6);
        s.exp.fault   = (st == 3'd7);
        s.exp.code    = code;
        s.exp.instret = modelInstret[CNT_W-1:0];
        if (pcw) modelInstret = (modelInstret + 1) % (1 << CNT_W);
        plan.push_back(s);
    endtask

    task automatic planFault(input logic [6:0] op, input logic [1:0] code);
        repeat (5) pushStep(op, rbit(), rbit(), 3'd7, 0, 0, 0, 0, 0, 0, code);
    endtask

    task automatic planIdle();
        pushStep(OP_R, rbit(), rbit(), 3'd0, 0, 0, 0, 0, 0, 0, 2'd0);
    endtask

    // One instruction: fetchWait/memWait are cycles without ack before the ack cycle.
    task automatic planInstr(input logic [6:0] op, input int fetchWait, input int memWait,
                             input int haltLen);
        logic isStore;
        isStore = (op == OP_STORE);
        for (int i = 0; i < fetchWait && i < MEM_TIMEOUT; i++)
            pushStep(op, 1'b0, rbit(), 3'd1, 1, 0, 0, 0, 0, 0, 2'd0);
        if (fetchWait >= MEM_TIMEOUT) begin
            planFault(op, 2'd2);
            return;
        end
        pushStep(op, 1'b1, rbit(), 3'd1, 1, 0, 0, 1, 0, 0, 2'd0);
        pushStep(op, rbit(), rbit(), 3'd2, 0, 0, 0, 0, 0, 0, 2'd0);
        if (!isLegal(op)) begin
            planFault(op, 2'd1);
            return;
        end
        if (op == OP_ECALL) begin
            for (int i = 0; i < haltLen; i++)
                pushStep(op, rbit(), 1'b0, 3'd6, 0, 0, 0, 0, 0, 0, 2'd0);
            pushStep(op, rbit(), 1'b1, 3'd6, 0, 0, 0, 0, 1, 0, 2'd0);
            return;
        end
        if (op == OP_BRANCH) begin
            pushStep(op, rbit(), rbit(), 3'd3, 0, 0, 0, 0, 1, 0, 2'd0);
            return;
        end
        pushStep(op, rbit(), rbit(), 3'd3, 0, 0, 0, 0, 0, 0, 2'd0);
        if (op == OP_LOAD || isStore) begin
            for (int i = 0; i < memWait && i < MEM_TIMEOUT; i++)
                pushStep(op, 1'b0, rbit(), 3'd4, 1, 1, isStore, 0, 0, 0, 2'd0);
            if (memWait >= MEM_TIMEOUT) begin
                planFault(op, 2'd3);
                return;
            end
            pushStep(op, 1'b1, rbit(), 3'd4, 1, 1, isStore, 0, isStore, 0, 2'd0);
            if (isStore) return;
        end
        pushStep(op, rbit(), rbit(), 3'd5, 0, 0, 0, 0, 1, 1, 2'd0);
    endtask

    task automatic applyStimulus(input step_t s, output outs_t obs);
        @(negedge clk);
        Op             = s.op;
        memBus.mem_ack = s.ack;
        resume         = s.res;
        #1;
        obs = sampleOutputs();
    endtask

    task automatic doReset();
        rstn = 1'b0;
        plan.delete();
        modelInstret = 0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        step_t s;
        outs_t obs;
        int    n = 0;
        #1;
        rstn         = 1'b0;
        modelInstret = 0;
        repeat (3) pushStep(OP_R, 1'b1, rbit(), 3'd0, 0, 0, 0, 0, 0, 0, 2'd0);
        while (plan.size() != 0) begin
            s = plan.pop_front();
            applyStimulus(s, obs);
            checks++;
            if (obs !== s.exp) begin
                errors++;
                $display("[TB] FAIL reset cycle %0d: got %h expected %h", n, obs, s.exp);
            end
            n++;
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        planIdle();
        s = plan.pop_front();
        applyStimulus(s, obs);
        checks++;
        if (obs !== s.exp) begin
            errors++;
            $display("[TB] FAIL reset_idle: got %h expected %h", obs, s.exp);
        end
    endtask

    task automatic test_r_type();
        step_t s;
        outs_t obs;
        int    n = 0;
        planInstr(OP_R, 0, 0, 0);
        while (plan.size() != 0) begin
            s = plan.pop_front();
            applyStimulus(s, obs);
            checks++;
            if (obs !== s.exp) begin
                errors++;
                $display("[TB] FAIL r_type cycle %0d: got %h expected %h", n, obs, s.exp);
            end
            n++;
        end
        @(negedge clk);
        #1;
        checks++;
        if (instret !== 4'd1) begin
            errors++;
            $display("[TB] FAIL r_type_instret: got %0d expected 1", instret);
        end
    endtask

    task automatic test_load_loop();
        step_t s;
        outs_t obs;
        int    n = 0;
        doReset();
        planIdle();
        planInstr(OP_LOAD, 0, 3, 0);
        repeat (4) planInstr(OP_LOAD, $urandom_range(0, 3), $urandom_range(0, 3), 0);
        while (plan.size() != 0) begin
            s = plan.pop_front();
            applyStimulus(s, obs);
            checks++;
            if (obs !== s.exp) begin
                errors++;
                $display("[TB] FAIL load_loop cycle %0d: got %h expected %h", n, obs, s.exp);
            end
            n++;
        end
        @(negedge clk);
        #1;
        checks++;
        if (instret !== 4'd5) begin
            errors++;
            $display("[TB] FAIL load_loop_instret: got %0d expected 5", instret);
        end
    endtask

    task automatic test_store_branch_halt();
        step_t s;
        outs_t obs;
        int    n = 0;
        planInstr(OP_STORE, 0, 2, 0);
        planInstr(OP_BRANCH, 1, 0, 0);
        planInstr(OP_STORE, 2, 0, 0);
        planInstr(OP_ECALL, 0, 0, 10);
        planInstr(OP_JAL, 0, 0, 0);
        while (plan.size() != 0) begin
            s = plan.pop_front();
            applyStimulus(s, obs);
            checks++;
            if (obs !== s.exp) begin
                errors++;
                $display("[TB] FAIL store_branch_halt cycle %0d: got %h expected %h", n, obs, s.exp);
            end
            n++;
        end
    endtask

    task automatic test_faults();
        step_t s;
        outs_t obs;
        int    n = 0;
        doReset();
        planIdle();
        planInstr(OP_BAD, 0, 0, 0);
        while (plan.size() != 0) begin
            s = plan.pop_front();
            applyStimulus(s, obs);
            checks++;
            if (obs !== s.exp) begin
                errors++;
                $display("[TB] FAIL illegal cycle %0d: got %h expected %h", n, obs, s.exp);
            end
            n++;
        end
        doReset();
        planIdle();
        planInstr(OP_R, MEM_TIMEOUT, 0, 0);
        while (plan.size() != 0) begin
            s = plan.pop_front();
            applyStimulus(s, obs);
            checks++;
            if (obs !== s.exp) begin
                errors++;
                $display("[TB] FAIL fetch_timeout cycle %0d: got %h expected %h", n, obs, s.exp);
            end
            n++;
        end
        doReset();
        planIdle();
        planInstr(OP_R, MEM_TIMEOUT - 1, 0, 0);
        planInstr(OP_LOAD, 0, MEM_TIMEOUT - 1, 0);
        planInstr(OP_STORE, 0, MEM_TIMEOUT, 0);
        while (plan.size() != 0) begin
            s = plan.pop_front();
            applyStimulus(s, obs);
            checks++;
            if (obs !== s.exp) begin
                errors++;
                $display("[TB] FAIL data_timeout cycle %0d: got %h expected %h", n, obs, s.exp);
            end
            n++;
        end
    endtask

    task automatic test_random();
        step_t      s;
        outs_t      obs;
        int         n = 0;
        logic [6:0] ops [10];
        ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_ECALL};
        doReset();
        planIdle();
        repeat (40)
            planInstr(ops[$urandom_range(0, 9)], $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 4));
        while (plan.size() != 0) begin
            s = plan.pop_front();
            applyStimulus(s, obs);
            checks++;
            if (obs !== s.exp) begin
                errors++;
                $display("[TB] FAIL random cycle %0d: got %h expected %h", n, obs, s.exp);
            end
            n++;
        end
    endtask

    task automatic test_reset_mid_mem();
        step_t s;
        outs_t obs;
        int    n = 0;
        int    memSeen = 0;
        planInstr(OP_LOAD, 0, 3, 0);
        while (plan.size() != 0 && memSeen < 2) begin
            s = plan.pop_front();
            applyStimulus(s, obs);
            checks++;
            if (obs !== s.exp) begin
                errors++;
                $display("[TB] FAIL mid_mem cycle %0d: got %h expected %h", n, obs, s.exp);
            end
            if (s.exp.st == 3'd4) memSeen++;
            n++;
        end
        rstn = 1'b0;
        #1;
        obs = sampleOutputs();
        checks++;
        if (obs !== outs_t'('0)) begin
            errors++;
            $display("[TB] FAIL mid_mem_reset: got %h expected %h", obs, outs_t'('0));
        end
        doReset();
        planIdle();
        planInstr(OP_LUI, 0, 0, 0);
        while (plan.size() != 0) begin
            s = plan.pop_front();
            applyStimulus(s, obs);
            checks++;
            if (obs !== s.exp) begin
                errors++;
                $display("[TB] FAIL after_reset cycle %0d: got %h expected %h", n, obs, s.exp);
            end
            n++;
        end
    endtask

    initial begin
        memBus.mem_ack = 1'b0;
        test_reset();
        test_r_type();
        test_load_loop();
        test_store_branch_halt();
        test_faults();
        test_random();
        test_reset_mid_mem();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
